microwave_cook_sequencer: RTL

Sequences one microwave cook cycle: holds cook time and power level, counts down seconds, and duty-cycles the magnetron enable over a fixed 10 s window. It produces the timer_done level consumed by MagnetronControl. It arbitrates the keypad commands (start/stop/clear/load) against the door interlock. It sits between the keypad/decoder front end and the magnetron control/drive stage.

---
 rtl/microwave_pkg.sv | 28 ++
 rtl/sec_prescaler.sv | 40 ++++
 rtl/microwave_cook_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared cook-sequencer types: state encoding, power/window limits, power clamp helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int POWER_MAX  = 10;
    localparam int WINDOW_SEC = 10;

    // Keypad can deliver 0 or 11..15; the duty window only understands 1..10.
    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        if (p == 4'd0) begin
            return 4'd1;
        end
        if (p > 4'(POWER_MAX)) begin
            return 4'(POWER_MAX);
        end
        return p;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle sec_tick every TICKS_PER_SEC enabled cycles.
// Latency: tick asserted combinationally during the last count of each second.
// Backpressure: none; clear zeroes the count, disable freezes it.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic sec_tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick must not depend on clear: the owner derives clear from the tick.
    assign sec_tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = sec_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_cook_sequencer.sv
// Cook-cycle sequencer: keypad/door arbitration, seconds countdown, 10 s magnetron duty window; MICROWAVE_CHIME_EN adds the end chime.
// Latency: commands sampled on a clk edge show on outputs just after it; door opening drops magnetron_en in the same cycle.
// Backpressure: none; command levels are sampled every cycle, highest priority wins (clear > stop > door open > start > load).
module microwave_cook_sequencer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SEC_W         = 12,
    parameter int QUICK_SEC     = 30,
    parameter int CHIME_SEC     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             door_closed,
    input  logic             load,
    input  logic [SEC_W-1:0] time_in,
    input  logic [3:0]       power_in,
    output logic             magnetron_en,
    output logic             timer_done,
    output logic [SEC_W-1:0] remaining,
    output logic [2:0]       state,
    output logic             chime
);

    localparam logic [SEC_W-1:0] QUICK_TIME = SEC_W'(QUICK_SEC);
    localparam logic [3:0]       WIN_LAST   = 4'(WINDOW_SEC - 1);

    state_t           state_q, state_d;
    logic [SEC_W-1:0] remaining_q, remaining_d;
    logic [3:0]       power_q, power_d;
    logic [3:0]       window_q, window_d;
    logic             start_armed_q, start_armed_d;
    logic             mag_req_q, mag_req_d;
    logic             done_q, done_d;

    logic             start_act;
    logic             load_act;
    logic             pre_en;
    logic             pre_clr;
    logic             sec_tick;

`ifdef MICROWAVE_CHIME_EN
    assign pre_en = (state_q == COOK) || (state_q == DONE);
`else
    assign pre_en = (state_q == COOK);
`endif

    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (pre_en),
        .clear    (pre_clr),
        .sec_tick (sec_tick)
    );

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        power_d       = power_q;
        window_d      = window_q;
        start_armed_d = start_armed_q;

        // Quick-start from IDLE needs start to have been seen low since IDLE was entered.
        start_act = start && door_closed &&
                    (((state_q == IDLE) && start_armed_q) ||
                     (state_q == READY) || (state_q == PAUSED));
        load_act  = load && ((state_q == IDLE) || (state_q == READY) || (state_q == DONE));

        if (clear) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else if (stop) begin
            if (state_q == COOK) begin
                state_d = PAUSED;
            end
        end else if (!door_closed) begin
            if (state_q == COOK) begin
                state_d = PAUSED;
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else if (start_act) begin
            state_d = COOK;
            if (state_q == IDLE) begin
                remaining_d = QUICK_TIME;
                power_d     = 4'(POWER_MAX);
            end
            if (state_q != PAUSED) begin
                window_d = '0;
            end
        end else if (load_act) begin
            remaining_d = time_in;
            power_d     = clamp_power(power_in);
            state_d     = (time_in != '0) ? READY : IDLE;
        end else if ((state_q == COOK) && sec_tick) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - 1'b1;
            end
            window_d = (window_q == WIN_LAST) ? 4'd0 : window_q + 4'd1;
            if (remaining_q <= SEC_W'(1)) begin
                state_d = DONE;
            end
        end

        if ((state_d == IDLE) && (state_q != IDLE)) begin
            start_armed_d = 1'b0;
        end else if ((state_q == IDLE) && !start) begin
            start_armed_d = 1'b1;
        end

        mag_req_d = (state_d == COOK) && (window_d < power_d);
        done_d    = (state_d == DONE);
        // Every state change restarts the second count so the first second after entry is full length.
        pre_clr   = (state_d != state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            power_q       <= 4'(POWER_MAX);
            window_q      <= '0;
            start_armed_q <= 1'b0;
            mag_req_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            power_q       <= power_d;
            window_q      <= window_d;
            start_armed_q <= start_armed_d;
            mag_req_q     <= mag_req_d;
            done_q        <= done_d;
        end
    end

`ifdef MICROWAVE_CHIME_EN
    localparam logic [SEC_W-1:0] CHIME_LEN = SEC_W'(CHIME_SEC);

    logic [SEC_W-1:0] chime_sec_q, chime_sec_d;
    logic             chime_q, chime_d;

    always_comb begin
        chime_sec_d = chime_sec_q;
        if ((state_d != DONE) || (state_q != DONE)) begin
            chime_sec_d = '0;
        end else if (sec_tick && (chime_sec_q < CHIME_LEN)) begin
            chime_sec_d = chime_sec_q + 1'b1;
        end
        chime_d = (state_d == DONE) && (chime_sec_d < CHIME_LEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chime_sec_q <= '0;
            chime_q     <= 1'b0;
        end else begin
            chime_sec_q <= chime_sec_d;
            chime_q     <= chime_d;
        end
    end

    assign chime = chime_q;
`else
    logic unused_chime_cfg;
    assign unused_chime_cfg = (CHIME_SEC != 0);
    assign chime            = 1'b0;
`endif

    assign magnetron_en = mag_req_q & door_closed;
    assign timer_done   = done_q;
    assign remaining    = remaining_q;
    assign state        = state_q;

endmodule
